// File: rtl/umem_arbiter_if.sv
// umem_arbiter_if: request/grant and memory-port signals of the unified memory arbiter
interface umem_arbiter_if #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
);
  logic              if_req;
  logic [AWIDTH-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DWIDTH-1:0] if_rdata;
  logic              d_req;
  logic              d_we;
  logic [AWIDTH-1:0] d_addr;
  logic [DWIDTH-1:0] d_wdata;
  logic [2:0]        d_funct3;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DWIDTH-1:0] d_rdata;
  logic [AWIDTH-1:0] mem_addr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [2:0]        mem_funct3;
  logic [DWIDTH-1:0] mem_rdata;
  logic              if_stall;
  logic              d_stall;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_read_en, mem_write_en, mem_funct3, if_stall, d_stall
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_funct3, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_addr, mem_wdata, mem_read_en, mem_write_en, mem_funct3, if_stall, d_stall
  );
endinterface

// File: rtl/umem_arbiter.sv
// umem_arbiter: shares one memory port between fetch and load/store; define UMEM_ARB_RR_EN for round-robin conflicts
module umem_arbiter #(
  parameter int AWIDTH      = 32,
  parameter int DWIDTH      = 32,
  parameter int DSTREAK_MAX = 4
) (
  input logic            clk,
  input logic            rst,
  umem_arbiter_if.slave  bus
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;
  localparam logic [2:0] F3_LW    = 3'b010;
  logic [1:0] rd_owner;
  logic       if_gnt;
  logic       d_gnt;
  logic       d_wins;
`ifdef UMEM_ARB_RR_EN
  logic last_d;
  assign d_wins = ~last_d;
  // remember which side took the most recent grant so conflicts alternate
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_d <= 1'b0;
    else if (if_gnt | d_gnt) last_d <= d_gnt;
`else
  logic [3:0] dstreak;
  assign d_wins = dstreak != 4'(DSTREAK_MAX);
  // count data grants taken while fetch waits; fetch wins once the bound is hit
  always_ff @(posedge clk or negedge rst)
    if (!rst) dstreak <= '0;
    else if (!bus.if_req || if_gnt) dstreak <= '0;
    else if (d_gnt) dstreak <= dstreak + 4'd1;
`endif
  // outputs are forced low while reset is asserted, so grants are qualified by rst
  assign d_gnt  = rst & bus.d_req & (~bus.if_req | d_wins);
  assign if_gnt = rst & bus.if_req & ~d_gnt;
  assign bus.if_gnt       = if_gnt;
  assign bus.d_gnt        = d_gnt;
  assign bus.if_stall     = rst & bus.if_req & ~if_gnt;
  assign bus.d_stall      = rst & bus.d_req & ~d_gnt;
  assign bus.mem_addr     = if_gnt ? bus.if_addr : d_gnt ? bus.d_addr : '0;
  assign bus.mem_wdata    = d_gnt ? bus.d_wdata : '0;
  assign bus.mem_read_en  = if_gnt | (d_gnt & ~bus.d_we);
  assign bus.mem_write_en = d_gnt & bus.d_we;
  assign bus.mem_funct3   = if_gnt ? F3_LW : d_gnt ? bus.d_funct3 : '0;
  assign bus.if_rvalid    = rd_owner == OWN_IF;
  assign bus.d_rvalid     = rd_owner == OWN_D;
  assign bus.if_rdata     = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata      = bus.d_rvalid ? bus.mem_rdata : '0;
  // record who issued this cycle's read so the returning word is steered next cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) rd_owner <= OWN_NONE;
    else rd_owner <= if_gnt ? OWN_IF : (d_gnt & ~bus.d_we) ? OWN_D : OWN_NONE;
endmodule

// File: tb/tb_umem_arbiter.sv
// tb_umem_arbiter: directed checks of the unified memory arbiter against a simple word memory
module tb_umem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [31:0] mem [256];
  umem_arbiter_if #(.AWIDTH(32), .DWIDTH(32)) bus ();
  umem_arbiter #(.AWIDTH(32), .DWIDTH(32), .DSTREAK_MAX(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  // word-addressed memory: write at issue, read data appears one cycle after issue
  always @(posedge clk) begin
    if (bus.mem_write_en) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    if (bus.mem_read_en) bus.mem_rdata <= mem[bus.mem_addr[9:2]];
  end

  task automatic idle();
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_funct3 = '0;
  endtask

  task automatic test_reset();
    idle();
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0000;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, bus.if_stall, bus.d_stall,
         bus.mem_read_en, bus.mem_write_en, bus.mem_funct3} !== '0 ||
        bus.mem_addr !== '0 || bus.mem_wdata !== '0 || bus.if_rdata !== '0 || bus.d_rdata !== '0) begin
      errors++; $display("FAIL reset_outputs: if_gnt=%b stall=%b addr=%h, required all zero", bus.if_gnt, bus.if_stall, bus.mem_addr);
    end
    @(negedge clk); rst = 1'b1; #1;
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h0100_0000 || bus.mem_funct3 !== 3'b010) begin
      errors++; $display("FAIL reset_release_gnt: gnt=%b addr=%h f3=%b, required 1 01000000 010", bus.if_gnt, bus.mem_addr, bus.mem_funct3);
    end
    @(negedge clk); idle();
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0000) begin
      errors++; $display("FAIL reset_release_rvalid: rvalid=%b rdata=%h, required 1 a0000000", bus.if_rvalid, bus.if_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_fetch_b2b();
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0000; #1;
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.mem_read_en !== 1'b1 || bus.mem_write_en !== 1'b0 || bus.mem_wdata !== '0) begin
      errors++; $display("FAIL fetch_gnt0: gnt=%b re=%b we=%b, required 1 1 0", bus.if_gnt, bus.mem_read_en, bus.mem_write_en);
    end
    @(negedge clk); bus.if_addr = 32'h0100_0004;
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0000 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL fetch_rdata0: rvalid=%b rdata=%h, required 1 a0000000", bus.if_rvalid, bus.if_rdata);
    end
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.mem_addr !== 32'h0100_0004) begin
      errors++; $display("FAIL fetch_gnt1: gnt=%b addr=%h, required 1 01000004", bus.if_gnt, bus.mem_addr);
    end
    @(negedge clk); idle();
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0001) begin
      errors++; $display("FAIL fetch_rdata1: rvalid=%b rdata=%h, required 1 a0000001", bus.if_rvalid, bus.if_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== '0) begin
      errors++; $display("FAIL fetch_rvalid_end: rvalid=%b rdata=%h, required 0 0", bus.if_rvalid, bus.if_rdata);
    end
  endtask

  task automatic test_conflict();
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0008;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0100_0100; bus.d_funct3 = 3'b010; #1;
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.if_stall !== 1'b1 || bus.d_stall !== 1'b0 ||
        bus.mem_addr !== 32'h0100_0100) begin
      errors++; $display("FAIL conflict_gnt: d_gnt=%b if_gnt=%b if_stall=%b d_stall=%b addr=%h, required 1 0 1 0 01000100",
                         bus.d_gnt, bus.if_gnt, bus.if_stall, bus.d_stall, bus.mem_addr);
    end
    @(negedge clk); bus.d_req = 1'b0;
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA000_0040 || bus.if_rvalid !== 1'b0 || bus.if_rdata !== '0) begin
      errors++; $display("FAIL conflict_rdata: d_rvalid=%b d_rdata=%h if_rvalid=%b if_rdata=%h, required 1 a0000040 0 0",
                         bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata);
    end
    #1;
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.if_stall !== 1'b0) begin
      errors++; $display("FAIL conflict_fetch_after: gnt=%b stall=%b, required 1 0", bus.if_gnt, bus.if_stall);
    end
    @(negedge clk); idle();
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0002 || bus.d_rvalid !== 1'b0) begin
      errors++; $display("FAIL conflict_fetch_rdata: rvalid=%b rdata=%h, required 1 a0000002", bus.if_rvalid, bus.if_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_streak();
    logic exp_d;
    bus.if_req = 1'b1; bus.if_addr = 32'h0100_0010;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0100_0020; bus.d_funct3 = 3'b010;
    for (int k = 0; k < 10; k++) begin
      #1;
`ifdef UMEM_ARB_RR_EN
      exp_d = (k % 2) == 0;
`else
      exp_d = (k % 5) != 4;
`endif
      checks++;
      if (bus.d_gnt !== exp_d || bus.if_gnt !== !exp_d || bus.if_stall !== exp_d || bus.d_stall !== !exp_d) begin
        errors++; $display("FAIL streak_%0d: d_gnt=%b if_gnt=%b, required %b %b", k, bus.d_gnt, bus.if_gnt, exp_d, !exp_d);
      end
      @(negedge clk);
    end
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store_load();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h0100_0200; bus.d_wdata = 32'hDEAD_BEEF; bus.d_funct3 = 3'b010; #1;
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_write_en !== 1'b1 || bus.mem_read_en !== 1'b0 || bus.mem_wdata !== 32'hDEAD_BEEF ||
        bus.mem_funct3 !== 3'b010) begin
      errors++; $display("FAIL store_issue: gnt=%b we=%b re=%b data=%h, required 1 1 0 deadbeef",
                         bus.d_gnt, bus.mem_write_en, bus.mem_read_en, bus.mem_wdata);
    end
    @(negedge clk); bus.d_we = 1'b0; bus.d_wdata = '0;
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin
      errors++; $display("FAIL store_no_rvalid: d_rvalid=%b if_rvalid=%b, required 0 0", bus.d_rvalid, bus.if_rvalid);
    end
    #1;
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_read_en !== 1'b1 || bus.mem_write_en !== 1'b0) begin
      errors++; $display("FAIL load_issue: gnt=%b re=%b we=%b, required 1 1 0", bus.d_gnt, bus.mem_read_en, bus.mem_write_en);
    end
    @(negedge clk); idle();
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL load_rdata: rvalid=%b rdata=%h, required 1 deadbeef", bus.d_rvalid, bus.d_rdata);
    end
    @(negedge clk);
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.mem_write_en !== 1'b0 || bus.mem_read_en !== 1'b0 || bus.mem_addr !== '0) begin
      errors++; $display("FAIL idle_outputs: rvalid=%b we=%b re=%b addr=%h, required 0 0 0 0",
                         bus.d_rvalid, bus.mem_write_en, bus.mem_read_en, bus.mem_addr);
    end
  endtask

  task automatic test_reset_inflight();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0100_0100; bus.d_funct3 = 3'b010; #1;
    checks++;
    if (bus.d_gnt !== 1'b1) begin
      errors++; $display("FAIL inflight_gnt: gnt=%b, required 1", bus.d_gnt);
    end
    @(posedge clk); #1; rst = 1'b0; idle(); #1;
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== '0) begin
      errors++; $display("FAIL inflight_during_reset: rvalid=%b rdata=%h, required 0 0", bus.d_rvalid, bus.d_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin
      errors++; $display("FAIL inflight_after_reset: d_rvalid=%b if_rvalid=%b, required 0 0", bus.d_rvalid, bus.if_rvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
    bus.mem_rdata = '0;
    idle();
    test_reset();
    test_fetch_b2b();
    test_conflict();
    test_streak();
    test_store_load();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
